// File: rtl/axi_lite_reg_slice_if.sv
// AXI4-Lite link bundle (AW, W, B, AR, R) used on both sides of the register slice.
// The master modport is the side that issues addresses and write data.
interface axi_lite_reg_slice_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);

   logic                      awvalid;
   logic                      awready;
   logic [ADDR_WIDTH-1:0]     awaddr;

   logic                      wvalid;
   logic                      wready;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [DATA_WIDTH/8-1:0]   wstrb;

   logic                      bvalid;
   logic                      bready;
   logic [1:0]                bresp;

   logic                      arvalid;
   logic                      arready;
   logic [ADDR_WIDTH-1:0]     araddr;

   logic                      rvalid;
   logic                      rready;
   logic [DATA_WIDTH-1:0]     rdata;
   logic [1:0]                rresp;

   modport master (
      output awvalid, awaddr,
      input  awready,
      output wvalid, wdata, wstrb,
      input  wready,
      input  bvalid, bresp,
      output bready,
      output arvalid, araddr,
      input  arready,
      input  rvalid, rdata, rresp,
      output rready
   );

   modport slave (
      input  awvalid, awaddr,
      output awready,
      input  wvalid, wdata, wstrb,
      output wready,
      output bvalid, bresp,
      input  bready,
      input  arvalid, araddr,
      output arready,
      output rvalid, rdata, rresp,
      input  rready
   );

endinterface

// File: rtl/axi_lite_reg_slice.sv
// AXI4-Lite register slice: every channel passes through its own 2-entry skid buffer
// so no valid, ready or payload path crosses the slice combinationally.

module axi_lite_skid #(
   parameter int WIDTH = 32
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic             src_valid,
   output logic             src_ready,
   input  logic [WIDTH-1:0] src_data,
   output logic             dst_valid,
   input  logic             dst_ready,
   output logic [WIDTH-1:0] dst_data
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } fill_t;

   fill_t            state;
   fill_t            state_next;
   logic [WIDTH-1:0] skid_data;
   logic             push;
   logic             pop;
   logic             load_out;
   logic             load_skid;
   logic             drain_skid;

   assign push = src_valid && src_ready;
   assign pop  = dst_valid && dst_ready;

   always_comb begin
      state_next = state;
      load_out   = 1'b0;
      load_skid  = 1'b0;
      drain_skid = 1'b0;
      case (state)
         EMPTY: begin
            if (push) begin
               state_next = ONE;
               load_out   = 1'b1;
            end
         end
         ONE: begin
            if (push && pop) begin
               load_out = 1'b1;
            end else if (push) begin
               state_next = FULL;
               load_skid  = 1'b1;
            end else if (pop) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            // src_ready is low here, so only the drain can happen
            if (pop) begin
               state_next = ONE;
               drain_skid = 1'b1;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state     <= EMPTY;
         src_ready <= 1'b0;
         dst_valid <= 1'b0;
         dst_data  <= '0;
         skid_data <= '0;
      end else begin
         state     <= state_next;
         src_ready <= (state_next != FULL);
         dst_valid <= (state_next != EMPTY);
         if (load_out) begin
            dst_data <= src_data;
         end else if (drain_skid) begin
            dst_data <= skid_data;
         end
         if (load_skid) begin
            skid_data <= src_data;
         end
      end
   end

endmodule

module axi_lite_reg_slice #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                   aclk,
   input  logic                   areset,
   axi_lite_reg_slice_if.slave    s_axi,
   axi_lite_reg_slice_if.master   m_axi
);

   // DATA_WIDTH is expected to be a whole number of bytes
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int W_WIDTH    = DATA_WIDTH + STRB_WIDTH;
   localparam int R_WIDTH    = DATA_WIDTH + 2;

   logic [W_WIDTH-1:0] w_in;
   logic [W_WIDTH-1:0] w_out;
   logic [R_WIDTH-1:0] r_in;
   logic [R_WIDTH-1:0] r_out;

   assign w_in        = {s_axi.wdata, s_axi.wstrb};
   assign m_axi.wdata = w_out[W_WIDTH-1:STRB_WIDTH];
   assign m_axi.wstrb = w_out[STRB_WIDTH-1:0];

   assign r_in        = {m_axi.rdata, m_axi.rresp};
   assign s_axi.rdata = r_out[R_WIDTH-1:2];
   assign s_axi.rresp = r_out[1:0];

   axi_lite_skid #(.WIDTH(ADDR_WIDTH)) aw_slice (
      .aclk      (aclk),
      .areset    (areset),
      .src_valid (s_axi.awvalid),
      .src_ready (s_axi.awready),
      .src_data  (s_axi.awaddr),
      .dst_valid (m_axi.awvalid),
      .dst_ready (m_axi.awready),
      .dst_data  (m_axi.awaddr)
   );

   axi_lite_skid #(.WIDTH(W_WIDTH)) w_slice (
      .aclk      (aclk),
      .areset    (areset),
      .src_valid (s_axi.wvalid),
      .src_ready (s_axi.wready),
      .src_data  (w_in),
      .dst_valid (m_axi.wvalid),
      .dst_ready (m_axi.wready),
      .dst_data  (w_out)
   );

   // Response channels run slave-to-master, so source and destination swap sides
   axi_lite_skid #(.WIDTH(2)) b_slice (
      .aclk      (aclk),
      .areset    (areset),
      .src_valid (m_axi.bvalid),
      .src_ready (m_axi.bready),
      .src_data  (m_axi.bresp),
      .dst_valid (s_axi.bvalid),
      .dst_ready (s_axi.bready),
      .dst_data  (s_axi.bresp)
   );

   axi_lite_skid #(.WIDTH(ADDR_WIDTH)) ar_slice (
      .aclk      (aclk),
      .areset    (areset),
      .src_valid (s_axi.arvalid),
      .src_ready (s_axi.arready),
      .src_data  (s_axi.araddr),
      .dst_valid (m_axi.arvalid),
      .dst_ready (m_axi.arready),
      .dst_data  (m_axi.araddr)
   );

   axi_lite_skid #(.WIDTH(R_WIDTH)) r_slice (
      .aclk      (aclk),
      .areset    (areset),
      .src_valid (m_axi.rvalid),
      .src_ready (m_axi.rready),
      .src_data  (r_in),
      .dst_valid (s_axi.rvalid),
      .dst_ready (s_axi.rready),
      .dst_data  (r_out)
   );

endmodule

// File: tb/tb_axi_lite_reg_slice.sv
// Directed and randomised checks of the AXI4-Lite register slice; the bench plays
// the interconnect on the upstream bus and the slave on the downstream bus.
module tb_axi_lite_reg_slice;

   logic aclk;
   logic areset;
   int   checks;
   int   failures;

   axi_lite_reg_slice_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) up_bus ();
   axi_lite_reg_slice_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) down_bus ();

   axi_lite_reg_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .aclk   (aclk),
      .areset (areset),
      .s_axi  (up_bus.slave),
      .m_axi  (down_bus.master)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic fail(input string name, input logic [63:0] got, input logic [63:0] want);
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
   endtask

   function automatic logic [35:0] chan_mask(input int c);
      logic [35:0] m;
      case (c)
         0, 2:    m = 36'h0_FFFF_FFFF;
         1:       m = 36'hF_FFFF_FFFF;
         3:       m = 36'h0_0000_0003;
         default: m = 36'h3_FFFF_FFFF;
      endcase
      return m;
   endfunction

   // Channel order in the random test: 0=AW 1=W 2=AR 3=B 4=R
   task automatic drive_pins(input logic [4:0] sv, input logic [35:0] sd [5], input logic [4:0] dr);
      up_bus.awvalid   = sv[0];
      up_bus.awaddr    = sd[0][31:0];
      up_bus.wvalid    = sv[1];
      up_bus.wdata     = sd[1][35:4];
      up_bus.wstrb     = sd[1][3:0];
      up_bus.arvalid   = sv[2];
      up_bus.araddr    = sd[2][31:0];
      down_bus.bvalid  = sv[3];
      down_bus.bresp   = sd[3][1:0];
      down_bus.rvalid  = sv[4];
      down_bus.rdata   = sd[4][33:2];
      down_bus.rresp   = sd[4][1:0];
      down_bus.awready = dr[0];
      down_bus.wready  = dr[1];
      down_bus.arready = dr[2];
      up_bus.bready    = dr[3];
      up_bus.rready    = dr[4];
   endtask

   task automatic sample_pins(output logic [4:0] sr, output logic [4:0] dv, output logic [35:0] dd [5]);
      sr    = {down_bus.rready, down_bus.bready, up_bus.arready, up_bus.wready, up_bus.awready};
      dv    = {up_bus.rvalid, up_bus.bvalid, down_bus.arvalid, down_bus.wvalid, down_bus.awvalid};
      dd[0] = {4'b0, down_bus.awaddr};
      dd[1] = {down_bus.wdata, down_bus.wstrb};
      dd[2] = {4'b0, down_bus.araddr};
      dd[3] = {34'b0, up_bus.bresp};
      dd[4] = {2'b0, up_bus.rdata, up_bus.rresp};
   endtask

   task automatic idle_pins();
      logic [35:0] z [5];
      for (int c = 0; c < 5; c++) z[c] = '0;
      drive_pins(5'b0, z, 5'b0);
   endtask

   task automatic test_reset();
      idle_pins();
      areset = 1'b1;
      up_bus.awvalid = 1'b1;
      up_bus.awaddr  = 32'hAAAA_5555;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({up_bus.bvalid, up_bus.rvalid, down_bus.awvalid, down_bus.wvalid, down_bus.arvalid} !== 5'b0)
            fail("reset_valids", {up_bus.bvalid, up_bus.rvalid, down_bus.awvalid, down_bus.wvalid, down_bus.arvalid}, 0);
         checks++;
         if ({up_bus.awready, up_bus.wready, up_bus.arready, down_bus.bready, down_bus.rready} !== 5'b0)
            fail("reset_readys", {up_bus.awready, up_bus.wready, up_bus.arready, down_bus.bready, down_bus.rready}, 0);
      end
      areset = 1'b0;
      tick();
      checks++;
      if ({up_bus.awready, up_bus.wready, up_bus.arready, down_bus.bready, down_bus.rready} !== 5'b11111)
         fail("release_readys", {up_bus.awready, up_bus.wready, up_bus.arready, down_bus.bready, down_bus.rready}, 5'b11111);
      checks++;
      if (down_bus.awvalid !== 1'b0) fail("reset_no_accept", down_bus.awvalid, 0);
      checks++;
      if (down_bus.awaddr !== 32'h0) fail("reset_payload", down_bus.awaddr, 0);
      up_bus.awvalid = 1'b0;
      up_bus.awaddr  = '0;
   endtask

   task automatic test_single_write();
      down_bus.awready = 1'b1;
      down_bus.wready  = 1'b1;
      up_bus.bready    = 1'b1;
      up_bus.awvalid   = 1'b1;
      up_bus.awaddr    = 32'h0000_0010;
      up_bus.wvalid    = 1'b1;
      up_bus.wdata     = 32'hDEAD_BEEF;
      up_bus.wstrb     = 4'hF;
      tick();
      up_bus.awvalid = 1'b0;
      up_bus.wvalid  = 1'b0;
      checks++;
      if (down_bus.awvalid !== 1'b1 || down_bus.awaddr !== 32'h10)
         fail("write_aw", {down_bus.awvalid, down_bus.awaddr}, {1'b1, 32'h10});
      checks++;
      if (down_bus.wvalid !== 1'b1 || down_bus.wdata !== 32'hDEAD_BEEF || down_bus.wstrb !== 4'hF)
         fail("write_w", {down_bus.wvalid, down_bus.wdata, down_bus.wstrb}, {1'b1, 32'hDEAD_BEEF, 4'hF});
      tick();
      checks++;
      if (down_bus.awvalid !== 1'b0 || down_bus.wvalid !== 1'b0)
         fail("write_drained", {down_bus.awvalid, down_bus.wvalid}, 0);
      for (int k = 0; k < 2; k++) begin
         logic [1:0] resp;
         resp = (k == 0) ? 2'b00 : 2'b10;
         down_bus.bvalid = 1'b1;
         down_bus.bresp  = resp;
         tick();
         down_bus.bvalid = 1'b0;
         checks++;
         if (up_bus.bvalid !== 1'b1 || up_bus.bresp !== resp)
            fail("write_bresp", {up_bus.bvalid, up_bus.bresp}, {1'b1, resp});
         tick();
         checks++;
         if (up_bus.bvalid !== 1'b0) fail("bresp_drained", up_bus.bvalid, 0);
      end
      down_bus.bresp = 2'b00;
   endtask

   task automatic test_backpressure();
      down_bus.arready = 1'b0;
      up_bus.arvalid   = 1'b1;
      up_bus.araddr    = 32'h04;
      tick();
      checks++;
      if (up_bus.arready !== 1'b1) fail("bp_ready_after_first", up_bus.arready, 1);
      up_bus.araddr = 32'h08;
      tick();
      up_bus.arvalid = 1'b0;
      checks++;
      if (up_bus.arready !== 1'b0) fail("bp_ready_full", up_bus.arready, 0);
      checks++;
      if (down_bus.arvalid !== 1'b1 || down_bus.araddr !== 32'h04)
         fail("bp_head", {down_bus.arvalid, down_bus.araddr}, {1'b1, 32'h04});
      tick();
      checks++;
      if (down_bus.arvalid !== 1'b1 || down_bus.araddr !== 32'h04 || up_bus.arready !== 1'b0)
         fail("bp_hold", {up_bus.arready, down_bus.arvalid, down_bus.araddr}, {1'b0, 1'b1, 32'h04});
      down_bus.arready = 1'b1;
      tick();
      checks++;
      if (down_bus.arvalid !== 1'b1 || down_bus.araddr !== 32'h08 || up_bus.arready !== 1'b1)
         fail("bp_second", {up_bus.arready, down_bus.arvalid, down_bus.araddr}, {1'b1, 1'b1, 32'h08});
      tick();
      checks++;
      if (down_bus.arvalid !== 1'b0) fail("bp_empty", down_bus.arvalid, 0);
   endtask

   task automatic test_streaming();
      up_bus.rready  = 1'b1;
      down_bus.rresp = 2'b00;
      for (int i = 0; i < 16; i++) begin
         down_bus.rvalid = 1'b1;
         down_bus.rdata  = i;
         tick();
         checks++;
         if (up_bus.rvalid !== 1'b1 || up_bus.rdata !== 32'(i) || up_bus.rresp !== 2'b00 || down_bus.rready !== 1'b1)
            fail("stream_beat", {down_bus.rready, up_bus.rvalid, up_bus.rdata, up_bus.rresp},
                 {1'b1, 1'b1, 32'(i), 2'b00});
      end
      down_bus.rvalid = 1'b0;
      tick();
      checks++;
      if (up_bus.rvalid !== 1'b0) fail("stream_end", up_bus.rvalid, 0);
   endtask

   task automatic test_random_stall();
      logic [4:0]  sv, sr, dv, dr, acc, hold;
      logic [35:0] sd [5];
      logic [35:0] dd [5];
      logic [35:0] hd [5];
      logic [35:0] sb [5][16];
      int          head [5];
      int          tail [5];
      logic [31:0] r1, r2;
      logic        gen;
      sv = '0; sr = '0; dv = '0; dr = '0; acc = '0; hold = '0;
      for (int c = 0; c < 5; c++) begin
         sd[c] = '0; dd[c] = '0; hd[c] = '0; head[c] = 0; tail[c] = 0;
      end
      for (int cyc = 0; cyc < 1030; cyc++) begin
         gen = (cyc < 1000);
         for (int c = 0; c < 5; c++) begin
            if (sv[c] && acc[c]) sv[c] = 1'b0;
            if (!sv[c] && gen && $urandom_range(0, 99) < 60) begin
               r1    = $urandom();
               r2    = $urandom();
               sv[c] = 1'b1;
               sd[c] = {r2[3:0], r1} & chan_mask(c);
            end
            dr[c] = gen ? ($urandom_range(0, 99) < 70) : 1'b1;
         end
         drive_pins(sv, sd, dr);
         sample_pins(sr, dv, dd);
         for (int c = 0; c < 5; c++) begin
            if (hold[c]) begin
               checks++;
               if (dv[c] !== 1'b1 || dd[c] !== hd[c])
                  fail($sformatf("stable_ch%0d", c), {dv[c], dd[c]}, {1'b1, hd[c]});
            end
            hold[c] = dv[c] && !dr[c];
            hd[c]   = dd[c];
            if (dv[c] && dr[c]) begin
               checks++;
               if (head[c] == tail[c]) begin
                  fail($sformatf("extra_beat_ch%0d", c), dd[c], 0);
               end else begin
                  if (dd[c] !== sb[c][head[c]])
                     fail($sformatf("order_ch%0d", c), dd[c], sb[c][head[c]]);
                  head[c] = (head[c] + 1) % 16;
               end
            end
            acc[c] = sv[c] && sr[c];
            if (acc[c]) begin
               sb[c][tail[c]] = sd[c];
               tail[c] = (tail[c] + 1) % 16;
            end
         end
         tick();
      end
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (head[c] != tail[c]) fail($sformatf("lost_ch%0d", c), 64'(tail[c]), 64'(head[c]));
      end
      idle_pins();
   endtask

   task automatic test_reset_midflight();
      down_bus.wready = 1'b0;
      up_bus.wvalid   = 1'b1;
      up_bus.wdata    = 32'h1111_1111;
      up_bus.wstrb    = 4'h1;
      tick();
      up_bus.wdata = 32'h2222_2222;
      up_bus.wstrb = 4'h2;
      tick();
      up_bus.wvalid = 1'b0;
      checks++;
      if (up_bus.wready !== 1'b0 || down_bus.wvalid !== 1'b1 || down_bus.wdata !== 32'h1111_1111)
         fail("mid_full", {up_bus.wready, down_bus.wvalid, down_bus.wdata}, {1'b0, 1'b1, 32'h1111_1111});
      areset = 1'b1;
      tick();
      areset = 1'b0;
      checks++;
      if (down_bus.wvalid !== 1'b0 || down_bus.wdata !== 32'h0 || down_bus.wstrb !== 4'h0)
         fail("mid_cleared", {down_bus.wvalid, down_bus.wdata, down_bus.wstrb}, 0);
      down_bus.wready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (down_bus.wvalid !== 1'b0) fail("mid_discarded", down_bus.wvalid, 0);
      end
      checks++;
      if (up_bus.wready !== 1'b1) fail("mid_ready_back", up_bus.wready, 1);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      areset   = 1'b1;
      test_reset();
      test_single_write();
      test_backpressure();
      test_streaming();
      test_random_stall();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_lite_reg_slice.md
Name: axi_lite_reg_slice

Overview:
- Full AXI4-Lite register slice between the interconnect's slave-side port and an axi_lite_slave.
- Breaks every combinational valid/ready/payload path on all five channels (AW, W, B, AR, R) to close timing.
- Protocol-transparent: no reordering, no channel coupling, no response generation.
- Each channel is an independent 2-entry skid buffer giving full throughput (one beat per cycle) with 1-cycle forward latency.

Parameters:
ADDR_WIDTH  32  width of AW/AR address payload
DATA_WIDTH  32  width of W/R data; must be a multiple of 8; strobe width is DATA_WIDTH/8

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  synchronous, active-high reset
s_awvalid/s_awready/s_awaddr  in/out/in  1/1/ADDR_WIDTH  upstream AW (from interconnect)
s_wvalid/s_wready/s_wdata/s_wstrb  in/out/in/in  1/1/DATA_WIDTH/DATA_WIDTH/8  upstream W
s_bvalid/s_bready/s_bresp  out/in/out  1/1/2  upstream B (to interconnect)
s_arvalid/s_arready/s_araddr  in/out/in  1/1/ADDR_WIDTH  upstream AR
s_rvalid/s_rready/s_rdata/s_rresp  out/in/out/out  1/1/DATA_WIDTH/2  upstream R
m_awvalid/m_awready/m_awaddr  out/in/out  1/1/ADDR_WIDTH  downstream AW (to slave)
m_wvalid/m_wready/m_wdata/m_wstrb  out/in/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8  downstream W
m_bvalid/m_bready/m_bresp  in/out/in  1/1/2  downstream B (from slave)
m_arvalid/m_arready/m_araddr  out/in/out  1/1/ADDR_WIDTH  downstream AR
m_rvalid/m_rready/m_rdata/m_rresp  in/out/in/in  1/1/DATA_WIDTH/2  downstream R

Behaviour:
- Channel buffer. Forward channels AW/W/AR map s_ to m_; reverse channels B/R map m_ to s_.
  - Each channel has 2 entries: an output register (drives the outgoing valid and payload) and a skid register.
  - Occupancy count 0..2.
  - Input ready = registered (count < 2), i.e. not combinationally dependent on the outgoing ready.
  - Outgoing valid = (count > 0), registered.
- Push occurs when in-valid && in-ready. Pop occurs when out-valid && out-ready.
  - count 0, push: data goes to the output register; out-valid is high the next cycle (1-cycle latency).
  - count 1, push and pop together: new data goes to the output register; count stays 1.
  - count 1, push without pop: data goes to the skid register; count becomes 2; in-ready drops the next cycle.
  - count 2, pop: skid moves to the output register; count becomes 1; in-ready rises the next cycle.
  - count 2, in-ready is 0, so no push is possible.
  - count 1, pop without push: count becomes 0.
- AXI stability: while out-valid && !out-ready, the outgoing payload and valid are held unchanged.
- Ordering: strict FIFO per channel; no interaction between channels. AW and W are passed independently, so either may lead.
- Data integrity: payload bits, including wstrb and resp, are passed bit-exact.
- Reset, while areset is high at a clock edge:
  - All counts are 0; all m_*valid and s_*valid outputs are 0.
  - All payload registers are 0.
  - All ready outputs (s_awready, s_wready, s_arready, m_bready, m_rready) are 0 during reset and 1 on the first cycle after areset deasserts.
- Reset mid-operation: buffered beats are discarded. Upstream and downstream are reset together.
- Throughput: back-to-back beats with the far side always ready give 1 beat/cycle sustained, with no bubbles.

Test Plan:
- Reset: hold areset 3 cycles with s_awvalid=1 -> all valids 0 and readys 0 during reset; readys =1 the cycle after release; no beat is accepted during reset.
- Single write: AW addr=0x0000_0010, W data=0xDEAD_BEEF strb=0xF, m_*ready=1 -> m_awvalid and m_wvalid appear 1 cycle later with the same payload. Slave bresp=2'b00 -> s_bvalid 1 cycle after m_bvalid, bresp=00.
- Backpressure: m_arready=0, push araddr 0x04 then 0x08 -> s_arready=0 from the cycle after the second push; m_araddr holds 0x04. Raise m_arready -> 0x04 then 0x08 are delivered on consecutive cycles; s_arready returns to 1.
- Streaming: 16 back-to-back reads with both sides always ready, rdata=i, rresp=00 -> 16 R beats on 16 consecutive cycles, in order, no bubbles.
- Random stall: random valid and ready toggling on all channels for 1000 cycles -> scoreboard shows no loss, duplication or reorder, and payload is stable whenever valid && !ready.
- Reset mid-flight: skid full on W (count 2), assert areset 1 cycle -> m_wvalid=0 next cycle; neither buffered beat ever appears downstream.
